// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
// Four-bank, 256-word x 16-bit memory. Each bank is blocked for three cycles
// after it accepts a request. Reads return two cycles after acceptance through
// a registered two-stage pipeline. At most one request is accepted per cycle.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//                (clears counters, busy, read pipeline; the array keeps its contents)
//   addr[15:0] : byte address; bank = addr[2:1], row = addr[10:3]
//   data_in    : write data
//   wr, rd     : level request inputs, sampled every cycle
//   data_out   : read data while data_valid=1, otherwise 16'h0000
//   data_valid : one-cycle pulse marking returned read data
//   stall      : combinational; a legal request targets a busy bank
//   busy[3:0]  : registered per-bank busy flags
//   err        : combinational; illegal request, dropped without side effects
//
// Configuration
//   BANKED_MEM_ADDR_CHECK_EN : when defined, addr[0]=1 or addr[15:11]!=0 is
//                              an illegal request. When undefined, those bits
//                              are ignored.
// -----------------------------------------------------------------------------
module banked_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    // Next value of a bank's down-counter: reload on accept, else count to 0.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic load);
        logic [1:0] nxt;
        if (load) begin
            nxt = 2'd3;
        end else begin
            case (cnt)
                2'd3:    nxt = 2'd2;
                2'd2:    nxt = 2'd1;
                2'd1:    nxt = 2'd0;
                default: nxt = 2'd0;
            endcase
        end
        return nxt;
    endfunction

    logic [1:0]  bank_s;
    logic [7:0]  row_s;
    logic [9:0]  idx_s;
    logic        req_s;
    logic        addr_bad_s;
    logic        err_s;
    logic        stall_s;
    logic        accept_s;
    logic        rd_en_s;
    logic        mem_we_s;
    logic [1:0]  cnt_next_s [4];
    logic [3:0]  busy_next_s;

    logic [1:0]  cnt_r [4];
    logic [3:0]  busy_r;
    logic [15:0] mem_r [1024];
    logic        s1_valid_r;
    logic [15:0] s1_data_r;
    logic        data_valid_r;
    logic [15:0] data_out_r;

`ifdef BANKED_MEM_ADDR_CHECK_EN
    assign addr_bad_s = addr[0] | (addr[15:11] != 5'd0);
`else
    logic unused_addr_s;
    assign addr_bad_s    = 1'b0;
    assign unused_addr_s = ^{addr[15:11], addr[0]};
`endif

    // Request decode: legality, stall and accept against the registered busy flags.
    always_comb begin
        bank_s   = addr[2:1];
        row_s    = addr[10:3];
        idx_s    = {bank_s, row_s};
        req_s    = rd | wr;
        err_s    = req_s & ((rd & wr) | addr_bad_s);
        stall_s  = 1'b0;
        accept_s = 1'b0;
        if (req_s && !err_s) begin
            stall_s  = busy_r[bank_s];
            accept_s = ~busy_r[bank_s];
        end else begin
            stall_s  = 1'b0;
            accept_s = 1'b0;
        end
        rd_en_s  = accept_s & rd;
        // The array is never written while reset is asserted.
        mem_we_s = accept_s & wr & rst_n;
    end

    // Per-bank counter next state; busy follows the next counter value so the
    // busy flag is itself a flop.
    always_comb begin
        busy_next_s = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            cnt_next_s[b]  = cnt_step(cnt_r[b], accept_s && (bank_s == 2'(b)));
            busy_next_s[b] = (cnt_next_s[b] != 2'd0);
        end
    end

    // Bank counters and busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                cnt_r[b] <= 2'd0;
            end
            busy_r <= 4'b0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_r[b] <= cnt_next_s[b];
            end
            busy_r <= busy_next_s;
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= data_in;
        end
    end

    // Two-stage read pipeline: stage 1 captures array data, stage 2 drives outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_data_r    <= 16'h0000;
            data_valid_r <= 1'b0;
            data_out_r   <= 16'h0000;
        end else begin
            s1_valid_r   <= rd_en_s;
            s1_data_r    <= rd_en_s ? mem_r[idx_s] : 16'h0000;
            data_valid_r <= s1_valid_r;
            data_out_r   <= s1_valid_r ? s1_data_r : 16'h0000;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign stall      = stall_s;
    assign err        = err_s;

endmodule

// File: tb/tb_banked_mem.sv
// -----------------------------------------------------------------------------
// tb_banked_mem
// Directed bench for banked_mem. Inputs change on the falling edge and every
// output is sampled 1 ns later, so each check observes the cycle whose rising
// edge follows.
// -----------------------------------------------------------------------------
module tb_banked_mem;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    banked_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", {12'h000, busy}, 16'h0000);
        chk("reset_valid", {15'h0000, data_valid}, 16'h0000);
        chk("reset_data", data_out, 16'h0000);

        // Write 0xBEEF to bank 2 on the first edge after release, read it back.
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 16'h0004, 16'hBEEF);
        chk("w_first_stall", {15'h0000, stall}, 16'h0000);
        chk("w_first_err", {15'h0000, err}, 16'h0000);
        idle();
        chk("w_busy_c1", {12'h000, busy}, 16'h0004);
        idle();
        idle();
        chk("w_busy_c3", {12'h000, busy}, 16'h0004);
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("r_c4_stall", {15'h0000, stall}, 16'h0000);
        chk("r_c4_busy", {12'h000, busy}, 16'h0000);
        idle();
        chk("r_c5_valid", {15'h0000, data_valid}, 16'h0000);
        chk("r_c5_busy", {12'h000, busy}, 16'h0004);
        idle();
        chk("r_c6_valid", {15'h0000, data_valid}, 16'h0001);
        chk("r_c6_data", data_out, 16'hBEEF);
        idle();
        chk("r_c7_valid", {15'h0000, data_valid}, 16'h0000);
        chk("r_c7_data", data_out, 16'h0000);

        // Same-bank hazard: write bank 1, then hold a bank-1 read until accepted.
        cyc(1'b0, 1'b1, 16'h0002, 16'h1234);
        chk("hz_w_stall", {15'h0000, stall}, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 16'h000A, 16'h0000);
            chk("hz_stall", {15'h0000, stall}, 16'h0001);
            chk("hz_busy", {12'h000, busy}, 16'h0002);
        end
        cyc(1'b1, 1'b0, 16'h000A, 16'h0000);
        chk("hz_accept", {15'h0000, stall}, 16'h0000);
        idle();
        chk("hz_c5_valid", {15'h0000, data_valid}, 16'h0000);
        idle();
        chk("hz_c6_valid", {15'h0000, data_valid}, 16'h0001);
        idle();
        idle();

        // Fill banks 0 and 3, then back-to-back reads across all four banks.
        cyc(1'b0, 1'b1, 16'h0000, 16'h1111);
        cyc(1'b0, 1'b1, 16'h0006, 16'h4444);
        chk("fill_consec_stall", {15'h0000, stall}, 16'h0000);
        idle();
        idle();
        idle();
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("pipe_c0_stall", {15'h0000, stall}, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0002, 16'h0000);
        chk("pipe_c1_stall", {15'h0000, stall}, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("pipe_c2_stall", {15'h0000, stall}, 16'h0000);
        chk("pipe_c2_valid", {15'h0000, data_valid}, 16'h0001);
        chk("pipe_c2_data", data_out, 16'h1111);
        cyc(1'b1, 1'b0, 16'h0006, 16'h0000);
        chk("pipe_c3_stall", {15'h0000, stall}, 16'h0000);
        chk("pipe_c3_busy", {12'h000, busy}, 16'h0007);
        chk("pipe_c3_data", data_out, 16'h1234);
        idle();
        chk("pipe_c4_valid", {15'h0000, data_valid}, 16'h0001);
        chk("pipe_c4_data", data_out, 16'hBEEF);
        idle();
        chk("pipe_c5_data", data_out, 16'h4444);
        idle();
        chk("pipe_c6_valid", {15'h0000, data_valid}, 16'h0000);
        chk("pipe_c6_data", data_out, 16'h0000);

        // rd and wr together: error, no stall, nothing changes.
        cyc(1'b1, 1'b1, 16'h0000, 16'h9999);
        chk("rw_err", {15'h0000, err}, 16'h0001);
        chk("rw_stall", {15'h0000, stall}, 16'h0000);
        chk("rw_busy", {12'h000, busy}, 16'h0000);
        idle();
        chk("rw_busy_after", {12'h000, busy}, 16'h0000);
        chk("rw_err_clear", {15'h0000, err}, 16'h0000);
        idle();
        chk("rw_no_valid", {15'h0000, data_valid}, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0002, 16'h5555);
        cyc(1'b1, 1'b1, 16'h0002, 16'h0000);
        chk("rw_busybank_err", {15'h0000, err}, 16'h0001);
        chk("rw_busybank_stall", {15'h0000, stall}, 16'h0000);
        chk("rw_busybank_busy", {12'h000, busy}, 16'h0002);
        idle();
        idle();
        chk("rw_busybank_nov", {15'h0000, data_valid}, 16'h0000);
        idle();

        // Reset one cycle after a read is accepted.
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("rst_rd_stall", {15'h0000, stall}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        rd    = 1'b0;
        #1;
        chk("rst_mid_busy", {12'h000, busy}, 16'h0000);
        chk("rst_mid_valid", {15'h0000, data_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_c2_valid", {15'h0000, data_valid}, 16'h0000);
        idle();
        chk("rst_c3_valid", {15'h0000, data_valid}, 16'h0000);

        // Array survived reset and the dropped rd&wr wrote nothing.
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle();
        chk("keep_b0_data", data_out, 16'h1111);
        idle();
        chk("keep_b1_data", data_out, 16'h5555);
        idle();

        // Out-of-range address bits.
        cyc(1'b1, 1'b0, 16'h0801, 16'h0000);
`ifdef BANKED_MEM_ADDR_CHECK_EN
        chk("addr_err", {15'h0000, err}, 16'h0001);
        chk("addr_stall", {15'h0000, stall}, 16'h0000);
        idle();
        idle();
        chk("addr_no_valid", {15'h0000, data_valid}, 16'h0000);
`else
        chk("addr_err", {15'h0000, err}, 16'h0000);
        chk("addr_stall", {15'h0000, stall}, 16'h0000);
        idle();
        idle();
        chk("addr_valid", {15'h0000, data_valid}, 16'h0001);
        chk("addr_data", data_out, 16'h1111);
`endif
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/banked_mem.md
BANKED_MEM -- requirements
Module: banked_mem

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: addr  input  16  byte address; word = addr[15:1], bank = addr[2:1], row = addr[10:3].
REQ-004 SHALL have port: data_in  input  16  write data.
REQ-005 SHALL have port: wr  input  1  write request, level, sampled each cycle.
REQ-006 SHALL have port: rd  input  1  read request, level, sampled each cycle.
REQ-007 SHALL have port: data_out  output  16  read data, valid only while data_valid=1, else 16'h0000.
REQ-008 SHALL have port: data_valid  output  1  one-cycle pulse marking returned read data.
REQ-009 SHALL have port: stall  output  1  combinational; request not accepted this cycle.
REQ-010 SHALL have port: busy  output  4  per-bank busy flags, registered.
REQ-011 SHALL have port: err  output  1  combinational; illegal request this cycle, request dropped.

Function
REQ-012 SHALL contain 4 banks × 256 words × 16 bits.
REQ-013 Request present = rd|wr; rd&wr both high SHALL assert err, be dropped, and leave all state unchanged.
REQ-014 A legal request SHALL be accepted in cycle N iff busy[bank]=0; otherwise stall=1, no state change; requester holds inputs.
REQ-015 stall SHALL be 0 when no request is present or when err=1.
REQ-016 On accept, the bank's 2-bit down-counter SHALL load 3; busy[b] = (counter[b] != 0); counter decrements each cycle to 0. busy[b] is high in cycles N+1..N+3; the bank accepts again in N+4.
REQ-017 Banks SHALL be independent: requests to different banks are accepted on consecutive cycles; max one accept per cycle.
REQ-018 Write accepted in N SHALL update the array at the rising edge ending cycle N.
REQ-019 Read accepted in N SHALL return array data with data_out/data_valid in cycle N+2 (two-stage registered pipeline carrying data and valid).
REQ-020 A read of a word SHALL return the last write to it accepted at an earlier cycle; a same-bank hazard is impossible by REQ-016.
REQ-021 Pipelined reads to different banks SHALL return in acceptance order, one per cycle, without bubbles.
REQ-022 busy SHALL not depend combinationally on the current request; stall and err SHALL be combinational on the inputs and busy.

Reset
REQ-023 rst_n=0 SHALL immediately clear: all bank counters, busy=4'b0000, both read-pipeline stages, data_valid=0, data_out=16'h0000.
REQ-024 Reset mid-operation SHALL discard in-flight reads (no data_valid after release) and SHALL leave array contents unchanged; the array is not reset.
REQ-025 The first rising edge with rst_n=1 SHALL be able to accept a request.

Configuration
REQ-026 Macro BANKED_MEM_ADDR_CHECK_EN defined: addr[0]=1 or addr[15:11]≠0 SHALL assert err and drop the request (no stall, no state change).
REQ-027 Macro BANKED_MEM_ADDR_CHECK_EN undefined: addr[0] and addr[15:11] SHALL be ignored; err is raised only for rd&wr.

Verification
REQ-028 Write 16'hBEEF to 16'h0004 in cycle 0, read 16'h0004 in cycle 4 -> stall=0 both; data_out=16'hBEEF, data_valid=1 in cycle 6 only.
REQ-029 Write 16'h0002 in cycle 0, read 16'h000A (same bank 1) held from cycle 1 -> stall=1 in cycles 1-3, busy=4'b0010 in cycles 1-3; accepted in cycle 4.
REQ-030 Reads to 16'h0000, 16'h0002, 16'h0004, 16'h0006 in cycles 0-3 -> no stall; data_valid=1 in cycles 2-5 with data in bank order 0,1,2,3.
REQ-031 rd=wr=1 at any address -> err=1, stall=0, busy unchanged, no data_valid two cycles later.
REQ-032 Read accepted in cycle 0, rst_n low in cycle 1 -> busy=0 and data_valid=0 immediately; no data_valid in cycle 2; previously written data still readable after release.
REQ-033 With BANKED_MEM_ADDR_CHECK_EN: read at 16'h0801 -> err=1, dropped; without it: same read accepted as a row-0/bank-0 read, err=0.
